multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Control FSM for a multicycle RV32I datapath. Sequences
//               FETCH/DECODE/EXEC/MEM/WB, times out stalled memory accesses
//               and traps illegal opcodes into a sticky FAULT state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSN,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rd_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        sub_sra,
  output logic        retire,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [2:0]  state
);

  // Counter holds 0..MEM_TIMEOUT-1; the last value plus another idle cycle is the timeout.
  localparam int                 c_cnt_w     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MEM_TIMEOUT - 1);

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_ialu   = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic [c_cnt_w-1:0]   w_wait_nxt;
  logic [1:0]           r_fault_code;
  logic [1:0]           w_code_nxt;
  logic                 r_br_taken;
  logic                 r_rel_seen;
  logic                 r_run;

  logic [6:0] w_opc;
  logic       w_is_rtype, w_is_ialu, w_is_load, w_is_store, w_is_branch;
  logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
  logic       w_rd_nz, w_alt_rtype, w_alt_ialu;
  logic       w_unused;

  assign w_opc       = INSN[6:0];
  assign w_is_rtype  = (w_opc == c_op_rtype);
  assign w_is_ialu   = (w_opc == c_op_ialu);
  assign w_is_load   = (w_opc == c_op_load);
  assign w_is_store  = (w_opc == c_op_store);
  assign w_is_branch = (w_opc == c_op_branch);
  assign w_is_jal    = (w_opc == c_op_jal);
  assign w_is_jalr   = (w_opc == c_op_jalr);
  assign w_is_lui    = (w_opc == c_op_lui);
  assign w_is_auipc  = (w_opc == c_op_auipc);
  assign w_legal     = w_is_rtype | w_is_ialu | w_is_load | w_is_store | w_is_branch |
                       w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
  assign w_rd_nz     = |INSN[11:7];
  // SLT/SLTU need a subtract; bit 30 selects SUB/SRA (shift-immediate only for I-type).
  assign w_alt_rtype = (~INSN[14] & INSN[13]) | INSN[30];
  assign w_alt_ialu  = (~INSN[14] & INSN[13]) | ((INSN[14:12] == 3'b101) & INSN[30]);
  assign w_unused    = ^{INSN[31], INSN[29:15]};

  assign state      = r_state;
  assign fault_code = r_fault_code;

  // State, wait counter and sticky fault code.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_fault_code <= 2'b00;
    end else begin
      r_state      <= w_next;
      r_wait_cnt   <= w_wait_nxt;
      r_fault_code <= w_code_nxt;
    end
  end

  // Reset-release qualifier (fetch starts on the second edge) and branch flag capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rel_seen <= 1'b0;
      r_run      <= 1'b0;
      r_br_taken <= 1'b0;
    end else begin
      r_rel_seen <= 1'b1;
      r_run      <= r_rel_seen;
      if (r_state == S_EXEC) begin
        r_br_taken <= branch_taken;
      end
    end
  end

  // Next-state and output decode; completion is tested before timeout so it wins.
  always_comb begin
    w_next      = r_state;
    w_wait_nxt  = '0;
    w_code_nxt  = r_fault_code;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rd_we       = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_next_sel = 1'b0;
    pc_alu_sel  = 1'b0;
    sub_sra     = 1'b0;
    retire      = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_run) begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            w_next = S_DECODE;
          end else if (r_wait_cnt == c_wait_last) begin
            w_next     = S_FAULT;
            w_code_nxt = 2'b01;
          end else begin
            w_wait_nxt = r_wait_cnt + c_cnt_w'(1);
          end
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next     = S_FAULT;
          w_code_nxt = 2'b10;
        end
      end
      S_EXEC: begin
        if (w_is_rtype) begin
          sub_sra = w_alt_rtype;
        end else if (w_is_ialu) begin
          sub_sra = w_alt_ialu;
        end else if (w_is_branch) begin
          sub_sra = 1'b1;
        end
        w_next = (w_is_load | w_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        addr_sel = 1'b1;
        mem_re   = w_is_load;
        mem_we   = w_is_store;
        if (mem_ready) begin
          w_next = S_WB;
        end else if (r_wait_cnt == c_wait_last) begin
          w_next     = S_FAULT;
          w_code_nxt = 2'b01;
        end else begin
          w_wait_nxt = r_wait_cnt + c_cnt_w'(1);
        end
      end
      S_WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        rd_we  = ~(w_is_store | w_is_branch) & w_rd_nz;
        if (w_is_jal || (w_is_branch && r_br_taken)) begin
          pc_next_sel = 1'b1;
          pc_alu_sel  = 1'b1;
        end else if (w_is_jalr) begin
          pc_next_sel = 1'b1;
        end
        w_next = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. An instruction-level
//               model expands each instruction into its expected per-cycle
//               output trace, which is then replayed against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] INSN = 32'h0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        ir_we, pc_we, rd_we, mem_re, mem_we, addr_sel;
  logic        pc_next_sel, pc_alu_sel, sub_sra, retire, fault;
  logic [1:0]  fault_code;
  logic [2:0]  state;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .INSN(INSN), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .rd_we(rd_we), .mem_re(mem_re), .mem_we(mem_we),
    .addr_sel(addr_sel), .pc_next_sel(pc_next_sel), .pc_alu_sel(pc_alu_sel),
    .sub_sra(sub_sra), .retire(retire), .fault(fault), .fault_code(fault_code), .state(state)
  );

  always #5 CLK = ~CLK;

  // Output bit masks for the expected-vector strobe field.
  localparam logic [10:0] B_IR  = 11'h400, B_PC  = 11'h200, B_RD  = 11'h100, B_RE  = 11'h080;
  localparam logic [10:0] B_WE  = 11'h040, B_AS  = 11'h020, B_PNS = 11'h010, B_PAS = 11'h008;
  localparam logic [10:0] B_SS  = 11'h004, B_RET = 11'h002, B_FLT = 11'h001, B_NONE = 11'h000;

  logic [15:0] obs;
  assign obs = {ir_we, pc_we, rd_we, mem_re, mem_we, addr_sel, pc_next_sel, pc_alu_sel,
                sub_sra, retire, fault, fault_code, state};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ov(input logic [2:0] st, input logic [10:0] s, input logic [1:0] code);
    return {s, code, st};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  typedef struct {
    logic        mr;
    logic        bt;
    logic [15:0] v;
  } step_t;

  step_t q[$];

  task automatic add(input logic mr, input logic bt, input logic [15:0] v);
    step_t s;
    s.mr = mr;
    s.bt = bt;
    s.v  = v;
    q.push_back(s);
  endtask

  // Replay queued cycles: drive just after the rising edge, compare on the falling edge.
  task automatic apply();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready    = s.mr;
      branch_taken = s.bt;
      @(negedge CLK);
      chk($sformatf("cyc%0d_st%0d", cyc, s.v[2:0]), 32'(obs), 32'(s.v));
      cyc++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic fault_tail(input logic [1:0] code);
    repeat (4) add(rb(), rb(), ov(3'd5, B_FLT, code));
  endtask

  // A memory access with n idle cycles: n>=MEM_TIMEOUT means the access times out.
  task automatic mem_access(input int n, input logic [2:0] st, input logic [10:0] s, output bit faulted);
    for (int k = 0; k < n && k < MEM_TIMEOUT; k++) add(1'b0, rb(), ov(st, s, 2'b00));
    if (n >= MEM_TIMEOUT) begin
      faulted = 1'b1;
      fault_tail(2'b01);
    end else begin
      faulted = 1'b0;
      add(1'b1, rb(), ov(st, s | ((st == 3'd0) ? B_IR : B_NONE), 2'b00));
    end
  endtask

  // Instruction-level reference: expands one instruction into its expected trace.
  task automatic gen(input logic [31:0] insn, input int fw, input int mw, input int btf, output bit faulted);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        b30, bt, ss, legal, is_ld, is_st, is_br, rdw;
    logic [10:0] wb;
    opc   = insn[6:0];
    f3    = insn[14:12];
    b30   = insn[30];
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    is_br = (opc == 7'b1100011);
    legal = opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    mem_access(fw, 3'd0, B_RE, faulted);
    if (faulted) return;
    add(rb(), rb(), ov(3'd1, B_NONE, 2'b00));
    if (!legal) begin
      fault_tail(2'b10);
      faulted = 1'b1;
      return;
    end
    bt = (btf < 0) ? rb() : 1'(btf);
    if (opc == 7'b0110011)      ss = (!f3[2] && f3[1]) || b30;
    else if (opc == 7'b0010011) ss = (!f3[2] && f3[1]) || (f3 == 3'b101 && b30);
    else                        ss = is_br;
    add(rb(), bt, ov(3'd2, ss ? B_SS : B_NONE, 2'b00));
    if (is_ld || is_st) begin
      mem_access(mw, 3'd3, B_AS | (is_ld ? B_RE : B_WE), faulted);
      if (faulted) return;
    end
    rdw = !(is_st || is_br) && (insn[11:7] != 5'd0);
    wb  = B_PC | B_RET | (rdw ? B_RD : B_NONE);
    if (opc == 7'b1101111 || (is_br && bt)) wb = wb | B_PNS | B_PAS;
    else if (opc == 7'b1100111)             wb = wb | B_PNS;
    add(rb(), rb(), ov(3'd4, wb, 2'b00));
  endtask

  // Reset pulse, then two idle cycles before fetch may start.
  task automatic do_reset();
    RST = 1'b1;
    #2;
    chk("reset_outputs", 32'(obs), 32'(ov(3'd0, B_NONE, 2'b00)));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    add(rb(), rb(), ov(3'd0, B_NONE, 2'b00));
    add(rb(), rb(), ov(3'd0, B_NONE, 2'b00));
    apply();
  endtask

  task automatic run(input logic [31:0] insn, input int fw, input int mw, input int btf);
    bit f;
    INSN = insn;
    gen(insn, fw, mw, btf, f);
    apply();
    if (f) do_reset();
  endtask

  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [31:0] r;
    int fw, mw;
    #1;
    do_reset();
    run(32'h002081B3, 0, 0, -1);           // ADD x3,x1,x2
    run(32'h402081B3, 3, 0, -1);           // SUB, fetch delayed
    run(32'h00208063, 0, 0, 1);            // BEQ taken
    run(32'h00208063, 1, 0, 0);            // BEQ not taken
    run(32'h0000A003, 0, 0, -1);           // LW x0
    run(32'h0020A083, 2, 15, -1);          // LW x1, completes on last allowed cycle
    run(32'h008000EF, 0, 0, -1);           // JAL
    run(32'h000080E7, 0, 0, -1);           // JALR
    run(32'h123452B7, 0, 0, -1);           // LUI
    run(32'h00001297, 0, 0, -1);           // AUIPC
    run(32'h4010D093, 0, 0, -1);           // SRAI
    run(32'h0020A093, 0, 0, -1);           // SLTI
    run(32'h40008093, 0, 0, -1);           // ADDI with imm bit 30 set
    run(32'h002081B3, 15, 0, -1);          // fetch completes on last allowed cycle
    run(32'h002081B3, 16, 0, -1);          // fetch timeout
    run(32'h0020A023, 0, 16, -1);          // SW timeout in MEM
    run(32'h0000007F, 0, 0, -1);           // illegal opcode

    // Asynchronous reset while a store is stalled in MEM.
    INSN = 32'h0020A023;
    add(1'b1, rb(), ov(3'd0, B_RE | B_IR, 2'b00));
    add(rb(), rb(), ov(3'd1, B_NONE, 2'b00));
    add(rb(), rb(), ov(3'd2, B_NONE, 2'b00));
    repeat (3) add(1'b0, rb(), ov(3'd3, B_AS | B_WE, 2'b00));
    apply();
    mem_ready = 1'b0;
    #2;
    chk("mem_we_before_rst", 32'(mem_we), 32'd1);
    RST = 1'b1;
    #1;
    chk("mem_we_async_drop", 32'(mem_we), 32'd0);
    chk("state_async_rst", 32'(state), 32'd0);
    do_reset();

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      run(r, fw, mw, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
